// File: rtl/reg_rd_if.sv
// Register-read bus between upstream requesters, the arbiter and the register file.
// The arbiter connects through the slave modport; the environment uses master.
interface reg_rd_if #(
  parameter int NUM_REQ    = 2,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic [NUM_REQ*ADDR_WIDTH-1:0] s_reg_rd_addr;
  logic [NUM_REQ-1:0]            s_reg_rd_en;
  logic [NUM_REQ*DATA_WIDTH-1:0] s_reg_rd_data;
  logic [NUM_REQ-1:0]            s_reg_rd_wait;
  logic [NUM_REQ-1:0]            s_reg_rd_ack;
  logic [ADDR_WIDTH-1:0]         m_reg_rd_addr;
  logic                          m_reg_rd_en;
  logic [DATA_WIDTH-1:0]         m_reg_rd_data;
  logic                          m_reg_rd_wait;
  logic                          m_reg_rd_ack;

  modport slave (
    input  s_reg_rd_addr, s_reg_rd_en, m_reg_rd_data, m_reg_rd_wait, m_reg_rd_ack,
    output s_reg_rd_data, s_reg_rd_wait, s_reg_rd_ack, m_reg_rd_addr, m_reg_rd_en
  );

  modport master (
    output s_reg_rd_addr, s_reg_rd_en, m_reg_rd_data, m_reg_rd_wait, m_reg_rd_ack,
    input  s_reg_rd_data, s_reg_rd_wait, s_reg_rd_ack, m_reg_rd_addr, m_reg_rd_en
  );
endinterface

// File: rtl/reg_rd_arbiter.sv
// Round-robin arbiter sharing one register-file read port among NUM_REQ requesters.
// Define REG_RD_ARB_TIMEOUT_EN to add a watchdog for reads that are never acknowledged.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | arbitrate among unmasked requesters, latch grant and address
// ISSUE    | first cycle of m_reg_rd_en; counter starts from zero
// WAIT_ACK | hold request and address until ack (or watchdog expiry)
// RESP     | one-cycle ack to the granted requester, update pointer, mask
module reg_rd_arbiter #(
  parameter int  NUM_REQ    = 2,
  parameter int  DATA_WIDTH = 32,
  parameter int  ADDR_WIDTH = 32,
  parameter int  TIMEOUT    = 16,
  localparam int GW         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  reg_rd_if.slave       bus,
  output logic [GW-1:0] grant_id,
  output logic          busy,
  output logic          timeout_err
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK, RESP} state_t;

  localparam logic [GW-1:0] LAST = GW'(NUM_REQ - 1);

  state_t                state_q, state_d;
  logic [GW-1:0]         grant_q, ptr_q, sel_idx, cand;
  logic                  sel_valid, mask_q;
  logic                  active, expire, complete, grant_load;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [NUM_REQ-1:0]    req_eff, ack_vec;
  logic [ADDR_WIDTH-1:0] addr_arr [NUM_REQ];
  logic [DATA_WIDTH-1:0] data_q   [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_slice
    assign addr_arr[i] = bus.s_reg_rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
    assign bus.s_reg_rd_data[i*DATA_WIDTH +: DATA_WIDTH] = data_q[i];
    assign ack_vec[i] = (state_q == RESP) && (grant_q == GW'(i));
  end

  assign active   = (state_q == ISSUE) || (state_q == WAIT_ACK);
  assign complete = active && (bus.m_reg_rd_ack || expire);

  // The requester just served still holds en for one cycle; keep it out of that round.
  always_comb begin
    req_eff = bus.s_reg_rd_en;
    if (mask_q) req_eff[grant_q] = 1'b0;
  end

  always_comb begin
    sel_valid = 1'b0;
    sel_idx   = '0;
    cand      = ptr_q;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = (cand == LAST) ? '0 : cand + GW'(1);
      if (!sel_valid && req_eff[cand]) begin
        sel_valid = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    grant_load = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (sel_valid) begin
          state_d    = ISSUE;
          grant_load = 1'b1;
        end
      end
      ISSUE:    state_d = complete ? RESP : WAIT_ACK;
      WAIT_ACK: if (complete) state_d = RESP;
      RESP:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_q <= '0;
      ptr_q   <= '0;
      mask_q  <= 1'b0;
      addr_q  <= '0;
      for (int i = 0; i < NUM_REQ; i++) data_q[i] <= '0;
    end else begin
      if (grant_load) begin
        grant_q <= sel_idx;
        addr_q  <= addr_arr[sel_idx];
      end
      // A watchdog abort returns zero data rather than whatever is on the bus.
      if (complete) data_q[grant_q] <= bus.m_reg_rd_ack ? bus.m_reg_rd_data : '0;
      if (state_q == RESP) ptr_q <= grant_q;
      mask_q <= (state_q == RESP);
    end
  end

`ifdef REG_RD_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT) + 1;

  logic [CW-1:0] tmo_cnt_q;
  logic          err_q;

  // Ack on the expiry cycle wins; a stretched read (wait high) never expires.
  assign expire = active && !bus.m_reg_rd_ack && !bus.m_reg_rd_wait &&
                  (tmo_cnt_q == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      if (grant_load)
        tmo_cnt_q <= '0;
      else if (active && !bus.m_reg_rd_ack && !bus.m_reg_rd_wait)
        tmo_cnt_q <= tmo_cnt_q + CW'(1);
      err_q <= expire;
    end
  end

  assign timeout_err = err_q;
`else
  logic unused_wait;
  assign unused_wait = bus.m_reg_rd_wait;
  assign expire      = 1'b0;
  assign timeout_err = 1'b0;
`endif

  assign bus.m_reg_rd_en   = active;
  assign bus.m_reg_rd_addr = addr_q;
  assign bus.s_reg_rd_ack  = ack_vec;
  assign bus.s_reg_rd_wait = bus.s_reg_rd_en & ~ack_vec;
  assign grant_id          = grant_q;
  assign busy              = (state_q != IDLE);

endmodule

// File: tb/tb_reg_rd_arbiter.sv
// Directed bench for reg_rd_arbiter: transaction-level model checked every cycle,
// plus literal cycle/data expectations for each scenario.
module tb_reg_rd_arbiter;
  localparam int N   = 2;
  localparam int DW  = 32;
  localparam int AW  = 32;
  localparam int TMO = 16;
  localparam int GW  = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  reg_rd_if #(.NUM_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();
  logic [GW-1:0] grant_id;
  logic          busy;
  logic          timeout_err;

  reg_rd_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .grant_id(grant_id), .busy(busy), .timeout_err(timeout_err)
  );

  // stimulus-side signals
  logic [N-1:0]  tb_en;
  logic [AW-1:0] tb_addr [N];
  logic          rf_ack, rf_wait;
  logic [DW-1:0] rf_data;
  for (genvar i = 0; i < N; i++) begin : g_addr
    assign bus.s_reg_rd_addr[i*AW +: AW] = tb_addr[i];
  end
  assign bus.s_reg_rd_en   = tb_en;
  assign bus.m_reg_rd_ack  = rf_ack;
  assign bus.m_reg_rd_wait = rf_wait;
  assign bus.m_reg_rd_data = rf_data;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit            md_men, md_err, md_mask;
  int            md_win, md_ptr, md_tcnt;
  logic [AW-1:0] md_addr;
  logic [GW-1:0] md_gid;
  logic [N-1:0]  md_sack;
  logic [DW-1:0] md_data [N];

  int            men_rise[$];
  int            sack_cyc[$];
  int            sack_id[$];
  logic [DW-1:0] sack_dat[$];
  int            err_cyc[$];
  bit            prev_men;
  logic [N-1:0]  ack_seen;

  function automatic int rr_pick(input int ptr, input logic [N-1:0] elig);
    for (int k = 1; k <= N; k++) begin
      int idx;
      idx = (ptr + k) % N;
      if (elig[idx]) return idx;
    end
    return 0;
  endfunction

  task automatic model_reset();
    md_men = 0; md_err = 0; md_mask = 0;
    md_win = 0; md_ptr = 0; md_tcnt = 0;
    md_addr = '0; md_gid = '0; md_sack = '0;
    for (int i = 0; i < N; i++) md_data[i] = '0;
  endtask

  task automatic monitor_step();
    logic [N-1:0] nsack, elig;
    bit           nerr, done;
    int           w;
    if (!rst_n) model_reset();
    chk("m_en", 64'(bus.m_reg_rd_en), 64'(md_men));
    if (md_men) chk("m_addr", 64'(bus.m_reg_rd_addr), 64'(md_addr));
    chk("s_ack", 64'(bus.s_reg_rd_ack), 64'(md_sack));
    chk("s_wait", 64'(bus.s_reg_rd_wait), 64'(tb_en & ~md_sack));
    chk("grant_id", 64'(grant_id), 64'(md_gid));
    chk("busy", 64'(busy), 64'(md_men || (md_sack != '0)));
    chk("timeout_err", 64'(timeout_err), 64'(md_err));
    for (int i = 0; i < N; i++)
      chk("s_data", 64'(bus.s_reg_rd_data[i*DW +: DW]), 64'(md_data[i]));

    if (bus.m_reg_rd_en && !prev_men) men_rise.push_back(cyc);
    prev_men = bus.m_reg_rd_en;
    for (int i = 0; i < N; i++)
      if (bus.s_reg_rd_ack[i]) begin
        sack_cyc.push_back(cyc);
        sack_id.push_back(i);
        sack_dat.push_back(bus.s_reg_rd_data[i*DW +: DW]);
      end
    if (timeout_err) err_cyc.push_back(cyc);
    ack_seen = bus.s_reg_rd_ack;

    if (rst_n) begin
      nsack = '0; nerr = 0; done = 0;
      if (md_men) begin
        if (bus.m_reg_rd_ack) begin
          md_data[md_win] = bus.m_reg_rd_data;
          done = 1;
        end
`ifdef REG_RD_ARB_TIMEOUT_EN
        else if (!bus.m_reg_rd_wait) begin
          if (md_tcnt == TMO - 1) begin
            md_data[md_win] = '0;
            nerr = 1;
            done = 1;
          end else md_tcnt++;
        end
`endif
        if (done) begin
          nsack[md_win] = 1'b1;
          md_men = 0;
          md_ptr = md_win;
        end
      end else if (md_sack == '0) begin
        elig = tb_en;
        if (md_mask) elig[md_win] = 1'b0;
        if (elig != '0) begin
          w       = rr_pick(md_ptr, elig);
          md_win  = w;
          md_men  = 1;
          md_gid  = GW'(w);
          md_addr = tb_addr[w];
          md_tcnt = 0;
        end
      end
      md_mask = (md_sack != '0);
      md_sack = nsack;
      md_err  = nerr;
    end
  endtask

  initial begin
    model_reset();
    prev_men = 0;
    ack_seen = '0;
    forever begin
      @(negedge clk);
      monitor_step();
    end
  end

  // ---------------- register file responder ----------------
  int            ack_at = 0, wait_len = 0, rf_k = 0;
  bit            never_ack = 0, spur = 0, use_fixed = 0, rf_prev = 0;
  logic [DW-1:0] fixed_data = '0;

  initial begin
    forever begin
      @(posedge clk); #1;
      if (bus.m_reg_rd_en) rf_k = rf_prev ? rf_k + 1 : 0;
      rf_prev = bus.m_reg_rd_en;
      rf_ack  = (bus.m_reg_rd_en && !never_ack && rf_k == ack_at) || (!bus.m_reg_rd_en && spur);
      rf_wait = bus.m_reg_rd_en && (rf_k < wait_len);
      if (rf_ack) rf_data = use_fixed ? fixed_data : {16'hA5A5, bus.m_reg_rd_addr[15:0]};
      else        rf_data = 32'hDEAD0000 | 32'(rf_k);
    end
  end

  // ---------------- requesters: hold en through the cycle after ack ----------------
  int rq_cnt [N];
  bit drop_pend [N];

  initial begin
    forever begin
      @(posedge clk); #1;
      for (int i = 0; i < N; i++) begin
        if (drop_pend[i]) begin
          tb_en[i] = 1'b0;
          drop_pend[i] = 0;
        end else if (ack_seen[i] && rq_cnt[i] > 0) begin
          rq_cnt[i]--;
          if (rq_cnt[i] > 0) tb_addr[i] = tb_addr[i] + 32'd4;
          else               drop_pend[i] = 1;
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic req(input int i, input int cnt, input logic [AW-1:0] a);
    rq_cnt[i]  = cnt;
    tb_addr[i] = a;
    tb_en[i]   = 1'b1;
  endtask

  task automatic clear_log();
    men_rise.delete(); sack_cyc.delete(); sack_id.delete();
    sack_dat.delete(); err_cyc.delete();
  endtask

  task automatic wait_quiet(input int budget);
    int n = 0;
    while ((tb_en != '0 || busy) && n < budget) begin
      tick(1);
      n++;
    end
    chk("quiet_within_budget", 64'(n < budget), 64'(1));
    tick(2);
  endtask

  initial begin
    #200000;
    $display("FAIL global_time_limit: got expired expected finish");
    $fatal(1, "time limit");
  end

  int c0;

  initial begin
    tb_en = '0;
    for (int i = 0; i < N; i++) begin
      tb_addr[i] = '0; rq_cnt[i] = 0; drop_pend[i] = 0;
    end
    rf_ack = 0; rf_wait = 0; rf_data = '0;
    rst_n = 0;
    tick(3);
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_m_en", 64'(bus.m_reg_rd_en), 64'(0));
    chk("rst_s_ack", 64'(bus.s_reg_rd_ack), 64'(0));
    chk("rst_grant", 64'(grant_id), 64'(0));
    rst_n = 1;
    tick(2);

    // single read, same-cycle ack
    clear_log();
    use_fixed = 1; fixed_data = 32'hCAFE0001; ack_at = 0; wait_len = 0;
    c0 = cyc;
    req(0, 1, 32'h10);
    wait_quiet(50);
    chk("single_n", 64'(sack_cyc.size()), 64'(1));
    if (sack_cyc.size() >= 1 && men_rise.size() >= 1) begin
      chk("single_men_cyc", 64'(men_rise[0]), 64'(c0 + 1));
      chk("single_ack_cyc", 64'(sack_cyc[0]), 64'(c0 + 2));
      chk("single_id", 64'(sack_id[0]), 64'(0));
      chk("single_data", 64'(sack_dat[0]), 64'(32'hCAFE0001));
    end
    chk("single_grant", 64'(grant_id), 64'(0));

    // contention: pointer 0 so requester 1 goes first
    clear_log();
    use_fixed = 0;
    c0 = cyc;
    req(0, 1, 32'h100);
    req(1, 1, 32'h200);
    wait_quiet(50);
    chk("cont_n", 64'(sack_cyc.size()), 64'(2));
    if (sack_cyc.size() >= 2) begin
      chk("cont_first_id", 64'(sack_id[0]), 64'(1));
      chk("cont_second_id", 64'(sack_id[1]), 64'(0));
      chk("cont_first_cyc", 64'(sack_cyc[0]), 64'(c0 + 2));
      chk("cont_second_cyc", 64'(sack_cyc[1]), 64'(c0 + 5));
      chk("cont_first_data", 64'(sack_dat[0]), 64'(32'hA5A50200));
      chk("cont_second_data", 64'(sack_dat[1]), 64'(32'hA5A50100));
    end

    // back-to-back from the same requester honours the mask cycle
    clear_log();
    c0 = cyc;
    req(0, 2, 32'h20);
    wait_quiet(50);
    chk("b2b_n", 64'(men_rise.size()), 64'(2));
    if (men_rise.size() >= 2 && sack_dat.size() >= 2) begin
      chk("b2b_first_men", 64'(men_rise[0]), 64'(c0 + 1));
      chk("b2b_spacing", 64'(men_rise[1] - men_rise[0]), 64'(4));
      chk("b2b_data1", 64'(sack_dat[1]), 64'(32'hA5A50024));
    end

    // delayed ack: 20 wait cycles
    clear_log();
    use_fixed = 1; fixed_data = 32'h12345678; ack_at = 20; wait_len = 20;
    c0 = cyc;
    req(1, 1, 32'h44);
    wait_quiet(100);
    chk("delay_n", 64'(sack_cyc.size()), 64'(1));
    if (sack_cyc.size() >= 1) begin
      chk("delay_ack_cyc", 64'(sack_cyc[0]), 64'(c0 + 22));
      chk("delay_data", 64'(sack_dat[0]), 64'(32'h12345678));
    end
    chk("delay_no_err", 64'(err_cyc.size()), 64'(0));

    // stray acks while idle or in response are ignored; alternating round robin
    clear_log();
    use_fixed = 0; ack_at = 2; wait_len = 0; spur = 1;
    tick(5);
    chk("spur_idle_ack", 64'(sack_cyc.size()), 64'(0));
    chk("spur_idle_busy", 64'(busy), 64'(0));
    req(0, 3, 32'h300);
    req(1, 3, 32'h400);
    wait_quiet(100);
    spur = 0;
    chk("rr_n", 64'(sack_id.size()), 64'(6));
    for (int j = 0; j < 6 && j < sack_id.size(); j++)
      chk("rr_order", 64'(sack_id[j]), 64'(j % 2));

    // never acknowledged
    clear_log();
    never_ack = 1; ack_at = 0;
    c0 = cyc;
    req(0, 1, 32'h50);
`ifdef REG_RD_ARB_TIMEOUT_EN
    wait_quiet(100);
    chk("tmo_err_n", 64'(err_cyc.size()), 64'(1));
    chk("tmo_ack_n", 64'(sack_cyc.size()), 64'(1));
    if (err_cyc.size() >= 1 && sack_cyc.size() >= 1) begin
      chk("tmo_err_cyc", 64'(err_cyc[0]), 64'(c0 + 1 + TMO));
      chk("tmo_ack_cyc", 64'(sack_cyc[0]), 64'(c0 + 1 + TMO));
      chk("tmo_data", 64'(sack_dat[0]), 64'(0));
    end
    req(0, 1, 32'h60);
    tick(4);
`else
    tick(40);
    chk("hang_busy", 64'(busy), 64'(1));
    chk("hang_m_en", 64'(bus.m_reg_rd_en), 64'(1));
    chk("hang_no_ack", 64'(sack_cyc.size()), 64'(0));
`endif

    // reset in the middle of WAIT_ACK
    rst_n = 0;
    #1;
    chk("midrst_m_en", 64'(bus.m_reg_rd_en), 64'(0));
    chk("midrst_busy", 64'(busy), 64'(0));
    chk("midrst_s_ack", 64'(bus.s_reg_rd_ack), 64'(0));
    tb_en = '0;
    for (int i = 0; i < N; i++) begin
      rq_cnt[i] = 0; drop_pend[i] = 0;
    end
    tick(2);
    rst_n = 1;
    never_ack = 0; ack_at = 0;
    tick(1);
    clear_log();
    c0 = cyc;
    req(0, 1, 32'h70);
    req(1, 1, 32'h80);
    wait_quiet(50);
    chk("post_rst_n", 64'(sack_id.size()), 64'(2));
    if (sack_id.size() >= 2 && men_rise.size() >= 1) begin
      chk("post_rst_first", 64'(sack_id[0]), 64'(1));
      chk("post_rst_second", 64'(sack_id[1]), 64'(0));
      chk("post_rst_men", 64'(men_rise[0]), 64'(c0 + 1));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
